// File: rtl/accumulator_deserializer.sv
// Receive end of the accumulator serial link: rebuilds SA/CML I/Q words
// from the serialStart/serialIn pair and counts good and aborted frames.
module accumulator_deserializer #(
  parameter int ACC_WIDTH     = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serialStart,
  input  logic                     serialIn,
  output logic [ACC_WIDTH-1:0]     dataSA_I,
  output logic [ACC_WIDTH-1:0]     dataSA_Q,
  output logic [ACC_WIDTH-1:0]     dataCML_I,
  output logic [ACC_WIDTH-1:0]     dataCML_Q,
  output logic                     dataValid,
  output logic                     frameError,
  output logic                     busy,
  output logic [ACC_WIDTH-1:0]     frameCount,
  output logic [ERR_CNT_WIDTH-1:0] errorCount
);

  localparam int FRAME_BITS = 4 * ACC_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [CNT_W-1:0]      r_bitCnt;

  logic [FRAME_BITS-1:0] w_next;
  logic [FRAME_BITS-1:0] w_first;
  logic                  w_last;

  assign w_next  = {r_shreg[FRAME_BITS-2:0], serialIn};
  assign w_first = {{(FRAME_BITS-1){1'b0}}, serialIn};
  assign w_last  = (r_bitCnt == CNT_W'(FRAME_BITS-1));
  assign busy    = (r_state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bitCnt   <= '0;
      dataSA_I   <= '0;
      dataSA_Q   <= '0;
      dataCML_I  <= '0;
      dataCML_Q  <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
      frameCount <= '0;
      errorCount <= '0;
    end else begin
      dataValid  <= 1'b0;
      frameError <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (serialStart) begin
            r_shreg  <= w_first;
            r_bitCnt <= CNT_W'(1);
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (serialStart) begin
            // Early marker: drop the partial frame, restart on this bit
            frameError <= 1'b1;
            if (errorCount != '1)
              errorCount <= errorCount + 1'b1;
            r_shreg  <= w_first;
            r_bitCnt <= CNT_W'(1);
          end else if (w_last) begin
            dataSA_I   <= w_next[4*ACC_WIDTH-1 -: ACC_WIDTH];
            dataSA_Q   <= w_next[3*ACC_WIDTH-1 -: ACC_WIDTH];
            dataCML_I  <= w_next[2*ACC_WIDTH-1 -: ACC_WIDTH];
            dataCML_Q  <= w_next[ACC_WIDTH-1 -: ACC_WIDTH];
            dataValid  <= 1'b1;
            frameCount <= frameCount + 1'b1;
            r_shreg    <= w_next;
            r_bitCnt   <= '0;
            r_state    <= IDLE;
          end else begin
            r_shreg  <= w_next;
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_deserializer.sv
// Scoreboard bench for accumulator_deserializer: driver pushes expected
// frames/errors, a monitor pops them when the DUT strobes.
module tb_accumulator_deserializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serialStart = 1'b0;
  logic        serialIn = 1'b0;
  logic [15:0] dataSA_I, dataSA_Q, dataCML_I, dataCML_Q;
  logic        dataValid, frameError, busy;
  logic [15:0] frameCount;
  logic [7:0]  errorCount;

  accumulator_deserializer #(.ACC_WIDTH(16), .ERR_CNT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .serialStart(serialStart),
    .serialIn   (serialIn),
    .dataSA_I   (dataSA_I),
    .dataSA_Q   (dataSA_Q),
    .dataCML_I  (dataCML_I),
    .dataCML_Q  (dataCML_Q),
    .dataValid  (dataValid),
    .frameError (frameError),
    .busy       (busy),
    .frameCount (frameCount),
    .errorCount (errorCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] w;
    logic [15:0] fc;
    int          cyc;
  } frm_t;

  typedef struct {
    logic [7:0] ec;
    int         cyc;
  } err_t;

  frm_t dq[$];
  err_t eq[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] exp_fc = '0;
  int          exp_ec = 0;
  bit          m_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every strobe against the head of its queue
  always @(posedge clk) begin
    #1;
    if (dataValid && frameError)
      chk("valid_and_error_same_cycle", 1, 0);
    if (dataValid) begin
      if (dq.size() == 0) begin
        chk("unexpected_dataValid", 1, 0);
      end else begin
        frm_t e;
        e = dq.pop_front();
        chk("frame_words",
            {dataSA_I, dataSA_Q, dataCML_I, dataCML_Q}, e.w);
        chk("frameCount_at_valid", 64'(frameCount), 64'(e.fc));
        chk("valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (dq.size() != 0 && cyc > dq[0].cyc) begin
      chk("missed_dataValid", 64'(cyc), 64'(dq[0].cyc));
      void'(dq.pop_front());
    end
    if (frameError) begin
      if (eq.size() == 0) begin
        chk("unexpected_frameError", 1, 0);
      end else begin
        err_t e;
        e = eq.pop_front();
        chk("errorCount_at_error", 64'(errorCount), 64'(e.ec));
        chk("error_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (eq.size() != 0 && cyc > eq[0].cyc) begin
      chk("missed_frameError", 64'(cyc), 64'(eq[0].cyc));
      void'(eq.pop_front());
    end
  end

  // Drive the first n bits of frame f, MSB first, marker on bit 0
  task automatic drive_bits(input logic [63:0] f, input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      serialStart = (i == 0);
      serialIn    = f[63-i];
      if (i == 0) begin
        s = cyc + 1;
        if (m_busy) begin
          if (exp_ec < 255) exp_ec++;
          eq.push_back('{ec: 8'(exp_ec), cyc: s});
        end
        m_busy = 1'b1;
      end
    end
    if (n == 64) begin
      exp_fc = exp_fc + 16'd1;
      dq.push_back('{w: f, fc: exp_fc, cyc: s + 63});
      m_busy = 1'b0;
    end
  endtask

  task automatic idle(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      serialStart = 1'b0;
      serialIn    = toggle ? i[0] : 1'b0;
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_data"},
        {dataSA_I, dataSA_Q, dataCML_I, dataCML_Q}, 64'h0);
    chk({name, "_flags"}, {61'h0, dataValid, frameError, busy}, 64'h0);
    chk({name, "_counts"}, {40'h0, frameCount, errorCount}, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    serialStart = 1'b0;
    serialIn    = 1'b0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset  = 1'b0;
    exp_fc = '0;
    exp_ec = 0;
    m_busy = 1'b0;
  endtask

  initial begin
    #2;
    chk_zero("power_on_reset");
    @(negedge clk);
    reset = 1'b0;
    idle(3, 1'b0);

    // 1: single frame
    drive_bits(64'h1234_ABCD_0001_8000, 64);
    idle(3, 1'b0);
    chk("t1_frameCount", 64'(frameCount), 64'd1);

    // 2: two frames with zero gap
    drive_bits(64'h1111_2222_3333_4444, 64);
    drive_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
    idle(3, 1'b0);
    chk("t2_frameCount", 64'(frameCount), 64'd3);
    chk("t2_words", {dataSA_I, dataSA_Q, dataCML_I, dataCML_Q},
        64'hFFFF_FFFF_FFFF_FFFF);

    // 3: marker at bit 20, then a full frame
    do_reset();
    drive_bits(64'hDEAD_BEEF_CAFE_F00D, 20);
    drive_bits(64'h5A5A_5A5A_5A5A_5A5A, 64);
    idle(3, 1'b0);
    chk("t3_errorCount", 64'(errorCount), 64'd1);
    chk("t3_frameCount", 64'(frameCount), 64'd1);

    // 4: reset at bit 30, then a fresh frame
    do_reset();
    drive_bits(64'hFEDC_BA98_7654_3210, 30);
    do_reset();
    drive_bits(64'h0F0F_1E1E_2D2D_3C3C, 64);
    idle(3, 1'b0);
    chk("t4_frameCount", 64'(frameCount), 64'd1);
    chk("t4_errorCount", 64'(errorCount), 64'd0);

    // 5: 300 aborted frames
    do_reset();
    for (int k = 0; k < 300; k++)
      drive_bits(64'hA5A5_A5A5_A5A5_A5A5, 10);
    chk("t5_errorCount", 64'(errorCount), 64'd255);
    chk("t5_frameCount", 64'(frameCount), 64'd0);
    chk("t5_data", {dataSA_I, dataSA_Q, dataCML_I, dataCML_Q}, 64'h0);

    // 6: toggling data with no marker holds everything
    do_reset();
    drive_bits(64'h5A5A_5A5A_5A5A_5A5A, 64);
    idle(2, 1'b0);
    for (int k = 0; k < 200; k++) begin
      idle(1, k[0]);
      chk("t6_busy", 64'(busy), 64'd0);
    end
    idle(2, 1'b0);
    chk("t6_words", {dataSA_I, dataSA_Q, dataCML_I, dataCML_Q},
        64'h5A5A_5A5A_5A5A_5A5A);
    chk("t6_frameCount", 64'(frameCount), 64'd1);

    idle(4, 1'b0);
    chk("pending_frames", 64'(dq.size()), 64'd0);
    chk("pending_errors", 64'(eq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
